psr_icc_unit: RTL and testbench
===============================

// Module: psr_icc_unit
// PURPOSE
//   Holds the 12-bit processor state register (PSR) and is the only block that writes it.
//   Its main job is updating the integer condition codes N,Z,V,C, which the branch/trap
//   condition tester reads.
//   It also keeps the window and trap state: CWP, S, PS and ET.
//   It checks SAVE, RESTORE and RETT against WIM and raises trap requests to the control unit.
//   PSR layout: [11:8]={N,Z,V,C}, [7]=S, [6]=PS, [5]=ET, [4:0]=CWP.
// PARAMETERS
//   NWINDOWS  4   number of register windows; CWP arithmetic is modulo NWINDOWS (2..32)
// PORTS
//   Clk          in   1         clock; all state changes on rising edge
//   Reset        in   1         asynchronous, active-high reset
//   cc_we        in   1         latch alu_nzvc into icc (cc-setting ALU op)
//   alu_nzvc     in   4         {N,Z,V,C} produced by ALU this cycle
//   save         in   1         SAVE executing
//   restore      in   1         RESTORE executing
//   rett         in   1         RETT executing
//   wrpsr        in   1         WRPSR executing
//   wr_data      in   12        new PSR value for WRPSR
//   trap_entry   in   1         control unit is entering a trap
//   WIM          in   NWINDOWS  window invalid mask
//   PSR          out  12        registered PSR
//   N,Z,V,C      out  1 each    condition codes to the condition tester
//   win_ovf      out  1         window-overflow trap request (1-cycle pulse)
//   win_unf      out  1         window-underflow trap request (1-cycle pulse)
//   priv_trap    out  1         privileged-instruction trap request (1-cycle pulse)
//   illeg_trap   out  1         illegal-instruction trap request (1-cycle pulse)
// BEHAVIOUR
//   - Reset (asynchronous, mid-operation included):
//     - PSR=12'h080 (S=1, all other fields 0); all trap pulses=0.
//   - Latency: every update is visible on PSR and the trap outputs one cycle after the request.
//   - Per-cycle priority: trap_entry > rett > wrpsr > save/restore. At most one of these is
//     acted on; a lower-priority request in the same cycle is dropped with no trap raised.
//   - trap_entry:
//     - CWP<=(CWP-1) mod NWINDOWS, PS<=S, S<=1, ET<=0.
//     - Ignores WIM and ET.
//     - A cc_we in the same cycle is still applied to icc.
//   - save:
//     - If WIM[(CWP-1) mod N]=1: win_ovf=1 and CWP is unchanged.
//     - Otherwise CWP decrements, wrapping 0 -> N-1.
//   - restore:
//     - If WIM[(CWP+1) mod N]=1: win_unf=1 and CWP is unchanged.
//     - Otherwise CWP increments, wrapping N-1 -> 0.
//   - rett, checked in this order:
//     - S=0: priv_trap.
//     - Else ET=1: illeg_trap.
//     - Else WIM[(CWP+1) mod N]=1: win_unf.
//     - Else: CWP+1 mod N, S<=PS, ET<=1.
//   - wrpsr, checked in this order:
//     - S=0: priv_trap, no write.
//     - Else wr_data[4:0]>=NWINDOWS: illeg_trap, no write.
//     - Else PSR<=wr_data, and a same-cycle cc_we is ignored (WRPSR wins icc).
//   - cc_we:
//     - icc<=alu_nzvc unless a successful wrpsr occurs in the same cycle.
//     - Independent of the CWP/S/ET updates.
//   - Trap pulses are mutually exclusive and last exactly one cycle.
//   - No field changes when no request is active.
// CONFIGURATION
//   - PSR_ICC_BYPASS_EN defined: N,Z,V,C = cc_we ? alu_nzvc : PSR[11:8] (combinational
//     forward), so a branch in the cycle after a cc op is resolved with fresh flags.
//     The PSR port stays registered.
//   - PSR_ICC_BYPASS_EN undefined: N,Z,V,C = PSR[11:8], purely registered.
// TESTING
//   - Reset asserted mid-save -> PSR=12'h080 immediately (asynchronous), no pulse; release
//     -> holds 12'h080.
//   - cc_we=1, alu_nzvc=4'b0100 -> next cycle Z=1, PSR[11:8]=4'b0100.
//     With bypass: Z=1 in the same cycle.
//   - N=4, CWP=0, WIM=4'b0000, save -> CWP=3.
//     Then WIM=4'b0100, save -> win_ovf for 1 cycle, CWP stays 3.
//   - PSR=12'h081, trap_entry -> PSR=12'h0C0 (S=1, PS=1, ET=0, CWP=0).
//     Then rett with WIM=0 -> PSR=12'h0E1.
//   - S=0, wrpsr wr_data=12'h0A0 -> priv_trap, PSR unchanged.
//     S=1, wr_data=12'h085 with N=4 -> illeg_trap.
//   - Same cycle wrpsr(12'h3A1) + cc_we(4'b1111) with S=1 -> PSR=12'h3A1.
//     trap_entry + save -> only trap_entry applied.

Source files
------------

// File: rtl/psr_icc_unit.sv
// psr_icc_unit
//   Owns the 12-bit processor state register and is the only block that writes it.
//   PSR layout: [11:8]={N,Z,V,C}, [7]=S, [6]=PS, [5]=ET, [4:0]=CWP.
//   Updates the integer condition codes and keeps the window and trap state
//   (CWP, S, PS, ET). It also checks SAVE, RESTORE, RETT and WRPSR and raises
//   one-cycle trap request pulses to the control unit.
//
//   Request priority per cycle: trap_entry > rett > wrpsr > save/restore.
//   At most one request is acted on. Lower-priority requests in the same cycle
//   are dropped silently. cc_we is independent of this ordering. The one
//   exception is a successful wrpsr, which takes the icc field.
//
//   Optional feature macro: PSR_ICC_BYPASS_EN
//     defined   : N,Z,V,C forward alu_nzvc combinationally while cc_we is high.
//     undefined : N,Z,V,C come straight from the registered PSR.
//   The PSR port is registered in both builds.
module psr_icc_unit #(
  parameter int NWINDOWS = 4
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                cc_we,
  input  logic [3:0]          alu_nzvc,
  input  logic                save,
  input  logic                restore,
  input  logic                rett,
  input  logic                wrpsr,
  input  logic [11:0]         wr_data,
  input  logic                trap_entry,
  input  logic [NWINDOWS-1:0] WIM,
  output logic [11:0]         PSR,
  output logic                N,
  output logic                Z,
  output logic                V,
  output logic                C,
  output logic                win_ovf,
  output logic                win_unf,
  output logic                priv_trap,
  output logic                illeg_trap
);

  // Highest legal window number. CWP never leaves the range 0..NWINDOWS-1.
  localparam logic [4:0] CWP_LAST = 5'(NWINDOWS - 1);

  // Reset value of the whole register: supervisor mode, all other fields 0.
  localparam logic [11:0] PSR_RESET = 12'h080;

  // Architectural state, one register per field.
  logic [3:0] r_icc;
  logic       r_s;
  logic       r_ps;
  logic       r_et;
  logic [4:0] r_cwp;

  // Registered trap request pulses.
  logic r_win_ovf;
  logic r_win_unf;
  logic r_priv_trap;
  logic r_illeg_trap;

  // Next-state values.
  logic [3:0] w_icc_nxt;
  logic       w_s_nxt;
  logic       w_ps_nxt;
  logic       w_et_nxt;
  logic [4:0] w_cwp_nxt;
  logic       w_win_ovf_nxt;
  logic       w_win_unf_nxt;
  logic       w_priv_trap_nxt;
  logic       w_illeg_trap_nxt;

  // Window arithmetic and WIM lookups.
  logic [4:0]          w_cwp_dec;
  logic [4:0]          w_cwp_inc;
  logic [NWINDOWS-1:0] w_wim_dec_sh;
  logic [NWINDOWS-1:0] w_wim_inc_sh;
  logic                w_wim_dec;
  logic                w_wim_inc;

  // WRPSR legality: the new CWP field must name an existing window.
  logic                w_wr_cwp_bad;

  // Modulo-NWINDOWS neighbours of the current window and their WIM bits.
  // Shifting instead of indexing keeps the 5-bit CWP independent of the WIM width.
  always_comb begin
    w_cwp_dec    = (r_cwp == 5'd0)     ? CWP_LAST : (r_cwp - 5'd1);
    w_cwp_inc    = (r_cwp == CWP_LAST) ? 5'd0     : (r_cwp + 5'd1);
    w_wim_dec_sh = WIM >> w_cwp_dec;
    w_wim_inc_sh = WIM >> w_cwp_inc;
    w_wim_dec    = w_wim_dec_sh[0];
    w_wim_inc    = w_wim_inc_sh[0];
    w_wr_cwp_bad = (32'(wr_data[4:0]) >= NWINDOWS);
  end

  // Next-state and trap decode. Only one request branch is taken per cycle,
  // which makes the trap pulses mutually exclusive by construction.
  always_comb begin
    w_icc_nxt        = r_icc;
    w_s_nxt          = r_s;
    w_ps_nxt         = r_ps;
    w_et_nxt         = r_et;
    w_cwp_nxt        = r_cwp;
    w_win_ovf_nxt    = 1'b0;
    w_win_unf_nxt    = 1'b0;
    w_priv_trap_nxt  = 1'b0;
    w_illeg_trap_nxt = 1'b0;

    // The condition codes follow the ALU unless a successful WRPSR overrides them below.
    if (cc_we) begin
      w_icc_nxt = alu_nzvc;
    end

    if (trap_entry) begin
      // Trap entry is unconditional. It ignores both WIM and ET.
      w_cwp_nxt = w_cwp_dec;
      w_ps_nxt  = r_s;
      w_s_nxt   = 1'b1;
      w_et_nxt  = 1'b0;
    end else if (rett) begin
      if (!r_s) begin
        w_priv_trap_nxt = 1'b1;
      end else if (r_et) begin
        w_illeg_trap_nxt = 1'b1;
      end else if (w_wim_inc) begin
        w_win_unf_nxt = 1'b1;
      end else begin
        w_cwp_nxt = w_cwp_inc;
        w_s_nxt   = r_ps;
        w_et_nxt  = 1'b1;
      end
    end else if (wrpsr) begin
      if (!r_s) begin
        w_priv_trap_nxt = 1'b1;
      end else if (w_wr_cwp_bad) begin
        w_illeg_trap_nxt = 1'b1;
      end else begin
        w_icc_nxt = wr_data[11:8];
        w_s_nxt   = wr_data[7];
        w_ps_nxt  = wr_data[6];
        w_et_nxt  = wr_data[5];
        w_cwp_nxt = wr_data[4:0];
      end
    end else if (save) begin
      // If save and restore are both asserted, save is the one honoured.
      if (w_wim_dec) begin
        w_win_ovf_nxt = 1'b1;
      end else begin
        w_cwp_nxt = w_cwp_dec;
      end
    end else if (restore) begin
      if (w_wim_inc) begin
        w_win_unf_nxt = 1'b1;
      end else begin
        w_cwp_nxt = w_cwp_inc;
      end
    end
  end

  // PSR field registers. Asynchronous reset returns the PSR to 12'h080.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_icc <= PSR_RESET[11:8];
      r_s   <= PSR_RESET[7];
      r_ps  <= PSR_RESET[6];
      r_et  <= PSR_RESET[5];
      r_cwp <= PSR_RESET[4:0];
    end else begin
      r_icc <= w_icc_nxt;
      r_s   <= w_s_nxt;
      r_ps  <= w_ps_nxt;
      r_et  <= w_et_nxt;
      r_cwp <= w_cwp_nxt;
    end
  end

  // Trap request pulses. Each is high for exactly the cycle after the request.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_win_ovf    <= 1'b0;
      r_win_unf    <= 1'b0;
      r_priv_trap  <= 1'b0;
      r_illeg_trap <= 1'b0;
    end else begin
      r_win_ovf    <= w_win_ovf_nxt;
      r_win_unf    <= w_win_unf_nxt;
      r_priv_trap  <= w_priv_trap_nxt;
      r_illeg_trap <= w_illeg_trap_nxt;
    end
  end

  // Registered outputs.
  always_comb begin
    PSR        = {r_icc, r_s, r_ps, r_et, r_cwp};
    win_ovf    = r_win_ovf;
    win_unf    = r_win_unf;
    priv_trap  = r_priv_trap;
    illeg_trap = r_illeg_trap;
  end

`ifdef PSR_ICC_BYPASS_EN
  // Forward fresh ALU flags, so a branch in the next cycle sees them immediately.
  always_comb begin
    {N, Z, V, C} = cc_we ? alu_nzvc : r_icc;
  end
`else
  // Condition codes come straight from the registered PSR.
  always_comb begin
    {N, Z, V, C} = r_icc;
  end
`endif

endmodule

// File: tb/tb_psr_icc_unit.sv
module tb_psr_icc_unit;

  localparam int NW = 4;

  logic          Clk;
  logic          Reset;
  logic          cc_we;
  logic [3:0]    alu_nzvc;
  logic          save;
  logic          restore;
  logic          rett;
  logic          wrpsr;
  logic [11:0]   wr_data;
  logic          trap_entry;
  logic [NW-1:0] WIM;
  logic [11:0]   PSR;
  logic          N, Z, V, C;
  logic          win_ovf, win_unf, priv_trap, illeg_trap;

  int n_checks;
  int n_pass;

  psr_icc_unit #(.NWINDOWS(NW)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .cc_we      (cc_we),
    .alu_nzvc   (alu_nzvc),
    .save       (save),
    .restore    (restore),
    .rett       (rett),
    .wrpsr      (wrpsr),
    .wr_data    (wr_data),
    .trap_entry (trap_entry),
    .WIM        (WIM),
    .PSR        (PSR),
    .N          (N),
    .Z          (Z),
    .V          (V),
    .C          (C),
    .win_ovf    (win_ovf),
    .win_unf    (win_unf),
    .priv_trap  (priv_trap),
    .illeg_trap (illeg_trap)
  );

  // Clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Single comparison point for every check.
  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%03h expected 0x%03h", tag, obs, exp);
    end
  endtask

  // Trap outputs packed as {ovf, unf, priv, illeg}.
  function automatic logic [11:0] traps();
    return {8'h00, win_ovf, win_unf, priv_trap, illeg_trap};
  endfunction

  function automatic logic [11:0] flags();
    return {8'h00, N, Z, V, C};
  endfunction

  task automatic clear_inputs();
    cc_we      = 1'b0;
    alu_nzvc   = 4'h0;
    save       = 1'b0;
    restore    = 1'b0;
    rett       = 1'b0;
    wrpsr      = 1'b0;
    wr_data    = 12'h000;
    trap_entry = 1'b0;
  endtask

  // Apply the currently driven request for one clock edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge Clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_wrpsr(input logic [11:0] d);
    wrpsr   = 1'b1;
    wr_data = d;
    tick();
  endtask

  // Watchdog so the run always finishes.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clear_inputs();
    WIM   = '0;
    Reset = 1'b1;
    #12;
    check("reset_psr", PSR, 12'h080);
    check("reset_traps", traps(), 12'h000);
    @(negedge Clk);
    Reset = 1'b0;
    tick();
    check("post_reset_psr", PSR, 12'h080);

    // Condition-code write.
    cc_we    = 1'b1;
    alu_nzvc = 4'b0100;
`ifdef PSR_ICC_BYPASS_EN
    #1;
    check("bypass_flags", flags(), 12'h004);
    check("bypass_psr_reg", PSR, 12'h080);
`endif
    tick();
    check("cc_psr", PSR, 12'h480);
    check("cc_flags", flags(), 12'h004);

    // Save with WIM clear wraps CWP 0 -> 3.
    save = 1'b1;
    tick();
    check("save_wrap_psr", PSR, 12'h483);
    check("save_wrap_traps", traps(), 12'h000);

    // Save into an invalid window overflows and leaves CWP unchanged.
    WIM  = 4'b0100;
    save = 1'b1;
    tick();
    check("save_ovf_traps", traps(), 12'h008);
    check("save_ovf_psr", PSR, 12'h483);
    tick();
    check("ovf_one_cycle", traps(), 12'h000);
    check("idle_hold_psr", PSR, 12'h483);

    // Restore into an invalid window underflows. Then it succeeds, wrapping 3 -> 0.
    WIM     = 4'b0001;
    restore = 1'b1;
    tick();
    check("restore_unf_traps", traps(), 12'h004);
    check("restore_unf_psr", PSR, 12'h483);
    WIM     = 4'b0000;
    restore = 1'b1;
    tick();
    check("restore_wrap_psr", PSR, 12'h480);
    check("restore_wrap_traps", traps(), 12'h000);

    // Trap entry and return.
    do_wrpsr(12'h081);
    check("wrpsr_081", PSR, 12'h081);
    trap_entry = 1'b1;
    tick();
    check("trap_entry_psr", PSR, 12'h0C0);
    rett = 1'b1;
    tick();
    check("rett_psr", PSR, 12'h0E1);
    check("rett_traps", traps(), 12'h000);
    rett = 1'b1;
    tick();
    check("rett_et1_traps", traps(), 12'h001);
    check("rett_et1_psr", PSR, 12'h0E1);

    // User mode: WRPSR and RETT are privileged.
    do_wrpsr(12'h041);
    check("wrpsr_user_psr", PSR, 12'h041);
    do_wrpsr(12'h0A0);
    check("wrpsr_priv_traps", traps(), 12'h002);
    check("wrpsr_priv_psr", PSR, 12'h041);
    rett = 1'b1;
    tick();
    check("rett_priv_traps", traps(), 12'h002);

    // Back to supervisor through a trap, then an out-of-range CWP write.
    trap_entry = 1'b1;
    tick();
    check("trap_from_user_psr", PSR, 12'h080);
    do_wrpsr(12'h085);
    check("wrpsr_illeg_traps", traps(), 12'h001);
    check("wrpsr_illeg_psr", PSR, 12'h080);

    // A successful WRPSR takes icc over a same-cycle cc_we.
    cc_we    = 1'b1;
    alu_nzvc = 4'b1111;
    do_wrpsr(12'h3A1);
    check("wrpsr_beats_cc", PSR, 12'h3A1);

    // Trap entry wins over save; the save's overflow is dropped too.
    WIM        = 4'b0001;
    trap_entry = 1'b1;
    save       = 1'b1;
    tick();
    check("trap_vs_save_psr", PSR, 12'h3C0);
    check("trap_vs_save_traps", traps(), 12'h000);

    // Trap entry still applies a same-cycle cc_we.
    trap_entry = 1'b1;
    cc_we      = 1'b1;
    alu_nzvc   = 4'b1000;
    tick();
    check("trap_cc_psr", PSR, 12'h8C3);
    check("trap_cc_flags", flags(), 12'h008);

    // RETT into an invalid window underflows.
    rett = 1'b1;
    tick();
    check("rett_unf_traps", traps(), 12'h004);
    check("rett_unf_psr", PSR, 12'h8C3);

    // RETT wins over WRPSR in the same cycle.
    WIM     = 4'b0000;
    rett    = 1'b1;
    wrpsr   = 1'b1;
    wr_data = 12'h000;
    tick();
    check("rett_vs_wrpsr_psr", PSR, 12'h8E0);
    check("rett_vs_wrpsr_traps", traps(), 12'h000);

    // Asynchronous reset in the middle of a save.
    WIM  = 4'b1000;
    save = 1'b1;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check("async_reset_psr", PSR, 12'h080);
    check("async_reset_traps", traps(), 12'h000);
    clear_inputs();
    #2;
    Reset = 1'b0;
    tick();
    check("after_async_psr", PSR, 12'h080);
    check("after_async_traps", traps(), 12'h000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
